// File: rtl/alu_pkg.sv
// Shared opcode and control-state definitions for the sequential ALU.
// Also intended for use by the control unit that drives SignalIn.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_DIVU = 4'b0100,
        OP_BNE  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MIN_WIDTH = 8;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/seq_divu.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge so the quotient is ready WIDTH-1 cycles later.
module seq_divu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] step_ld, step_run;

    // {remainder, quotient} after shifting in the next dividend bit and trial-subtracting
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {r, q[WIDTH-1]};
        diff = sh - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    assign step_ld  = div_step('0, dividend, divisor);
    assign step_run = div_step(remainder, quotient, dvs);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cnt       <= '0;
            dvs       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (start) begin
            busy                  <= 1'b1;
            cnt                   <= CW'(WIDTH - 1);
            dvs                   <= divisor;
            {remainder, quotient} <= step_ld;
        end else if (busy) begin
            {remainder, quotient} <= step_run;
            cnt                   <= cnt - CW'(1);
            busy                  <= (cnt != CW'(1));
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, iterative unsigned divide.
// Results are registered at accept (or at divide completion) and held until the next done.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       SignalIn,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             CarryOut,
    output logic             zero
);

    state_e state, state_n;

    logic             accept, is_divu, b_zero, div_go;
    logic             div_busy;
    logic [WIDTH-1:0] div_q, div_r;

    logic [WIDTH:0]   sum_add, sum_sub;
    logic             slt_ovf, slt_lt;
    logic [WIDTH-1:0] res_out;
    logic             res_c, res_z;

    assign ready   = (state == IDLE);
    assign done    = (state == DONE);
    assign accept  = ready && start;
    assign is_divu = (SignalIn == OP_DIVU);
    assign b_zero  = (inputB == '0);
    assign div_go  = accept && is_divu && !b_zero;

    seq_divu #(.WIDTH(WIDTH)) u_divu (
        .clk       (clk),
        .rst       (rst),
        .start     (div_go),
        .dividend  (inputA),
        .divisor   (inputB),
        .busy      (div_busy),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Single-cycle datapath, evaluated against the live operands at accept
    always_comb begin
        sum_add = {1'b0, inputA} + {1'b0, inputB};
        sum_sub = {1'b0, inputA} + {1'b0, ~inputB} + (WIDTH+1)'(1);
        slt_ovf = (inputA[WIDTH-1] != inputB[WIDTH-1]) && (sum_sub[WIDTH-1] != inputA[WIDTH-1]);
        slt_lt  = sum_sub[WIDTH-1] ^ slt_ovf;
        res_out = '0;
        res_c   = 1'b0;
        res_z   = 1'b0;
        case (SignalIn)
            OP_AND: begin
                res_out = inputA & inputB;
                res_z   = (res_out == '0);
            end
            OP_OR: begin
                res_out = inputA | inputB;
                res_z   = (res_out == '0);
            end
            OP_ADD: begin
                res_out = sum_add[WIDTH-1:0];
                res_c   = sum_add[WIDTH];
                res_z   = (res_out == '0);
            end
            OP_SUB: begin
                res_out = sum_sub[WIDTH-1:0];
                res_c   = sum_sub[WIDTH];
                res_z   = (res_out == '0);
            end
            OP_BNE: begin
                res_out = sum_sub[WIDTH-1:0];
                res_c   = sum_sub[WIDTH];
                res_z   = (inputA == inputB);
            end
            OP_SLT: begin
                res_out = {{(WIDTH-1){1'b0}}, slt_lt};
                res_z   = !slt_lt;
            end
            OP_SLL: begin
                res_out = inputA << inputB[SHW-1:0];
                res_z   = (res_out == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = div_go ? DIV : DONE;
            DIV:  if (!div_busy) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            out      <= '0;
            hi       <= '0;
            CarryOut <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept && is_divu && b_zero) begin
                out      <= '1;
                hi       <= inputA;
                CarryOut <= 1'b0;
                zero     <= 1'b0;
            end else if (accept && !is_divu) begin
                out      <= res_out;
                hi       <= '0;
                CarryOut <= res_c;
                zero     <= res_z;
            end else if (state == DIV && !div_busy) begin
                out      <= div_q;
                hi       <= div_r;
                CarryOut <= 1'b0;
                zero     <= (div_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;

    localparam int W = 32;
    localparam logic [3:0] AND_ = 4'h0, OR_ = 4'h1, ADD_ = 4'h2, SLL_ = 4'h3,
                           DIVU_ = 4'h4, BNE_ = 4'h5, SUB_ = 4'h6, SLT_ = 4'h7;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   SignalIn;
    logic [W-1:0] inputA, inputB;
    logic         ready, done, CarryOut, zero;
    logic [W-1:0] out, hi;

    int nvec = 0;
    int nerr = 0;
    int lat;
    int busy_cnt;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .SignalIn(SignalIn),
        .inputA(inputA), .inputB(inputB), .ready(ready), .done(done),
        .out(out), .hi(hi), .CarryOut(CarryOut), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE and wait (bounded) for done; returns at the done cycle's negedge
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int l);
        @(negedge clk);
        SignalIn = op; inputA = a; inputB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l = 1;
        while (!done && l < 100) begin
            @(negedge clk);
            l++;
        end
        if (!done) chk("timeout", 64'(l), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; SignalIn = '0; inputA = '0; inputB = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1));
        chk("rst_done",  64'(done),  64'(0));
        chk("rst_out",   64'(out),   64'(0));
        rst = 1'b0;

        run_op(ADD_, 32'hFFFF_FFFF, 32'h1, lat);
        chk("add_lat", 64'(lat), 64'(1));
        chk("add_out", 64'(out), 64'(0));
        chk("add_c",   64'(CarryOut), 64'(1));
        chk("add_z",   64'(zero), 64'(1));
        @(negedge clk);
        chk("add_done_once", 64'(done), 64'(0));
        chk("add_ready_back", 64'(ready), 64'(1));

        run_op(SLT_, 32'h8000_0000, 32'h1, lat);
        chk("slt_neg", 64'(out), 64'(1));
        run_op(SLT_, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("slt_ovf", 64'(out), 64'(0));
        chk("slt_z",   64'(zero), 64'(1));

        run_op(SLL_, 32'h1, 32'h25, lat);
        chk("sll_out", 64'(out), 64'h20);
        chk("sll_c",   64'(CarryOut), 64'(0));

        run_op(AND_, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
        chk("and_out", 64'(out), 64'h00F0_1200);
        run_op(OR_, 32'hF0F0_1234, 32'h0FF0_FF00, lat);
        chk("or_out", 64'(out), 64'hFFF0_FF34);

        // Divide with ignored start pulses and operand churn while busy
        @(negedge clk);
        SignalIn = DIVU_; inputA = 32'd100; inputB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (!ready) busy_cnt++;
            if (lat >= 3 && lat <= 10) begin
                start = 1'b1; SignalIn = ADD_; inputA = 32'h55; inputB = 32'h0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!ready) busy_cnt++;
        chk("divu_lat",  64'(lat), 64'(33));
        chk("divu_busy", 64'(busy_cnt), 64'(33));
        chk("divu_q",    64'(out), 64'(14));
        chk("divu_r",    64'(hi),  64'(2));
        @(negedge clk);
        chk("divu_done_once", 64'(done), 64'(0));
        chk("divu_hold", 64'(out), 64'(14));

        run_op(DIVU_, 32'hFFFF_FFFF, 32'h10, lat);
        chk("divu2_q", 64'(out), 64'h0FFF_FFFF);
        chk("divu2_r", 64'(hi),  64'hF);

        run_op(DIVU_, 32'h1234, 32'h0, lat);
        chk("div0_lat", 64'(lat), 64'(1));
        chk("div0_q",   64'(out), 64'hFFFF_FFFF);
        chk("div0_r",   64'(hi),  64'h1234);

        run_op(BNE_, 32'h55, 32'h55, lat);
        chk("bne_z", 64'(zero), 64'(1));
        chk("bne_hi", 64'(hi), 64'(0));
        run_op(SUB_, 32'h55, 32'h56, lat);
        chk("sub_out", 64'(out), 64'hFFFF_FFFF);
        chk("sub_c",   64'(CarryOut), 64'(0));
        chk("sub_z",   64'(zero), 64'(0));
        run_op(SUB_, 32'h56, 32'h55, lat);
        chk("sub2_out", 64'(out), 64'h1);
        chk("sub2_c",   64'(CarryOut), 64'(1));

        run_op(4'hF, 32'h1, 32'h1, lat);
        chk("bad_lat", 64'(lat), 64'(1));
        chk("bad_out", 64'(out), 64'(0));
        chk("bad_flags", 64'({CarryOut, zero}), 64'(0));

        // Establish nonzero outputs, then abort a division with reset
        run_op(ADD_, 32'h7, 32'h8, lat);
        @(negedge clk);
        SignalIn = DIVU_; inputA = 32'd1000; inputB = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out",   64'(out), 64'(0));
        chk("abort_hi",    64'(hi), 64'(0));
        chk("abort_flags", 64'({CarryOut, zero}), 64'(0));
        chk("abort_ready", 64'(ready), 64'(1));
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) busy_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(busy_cnt), 64'(0));
        run_op(ADD_, 32'd2, 32'd3, lat);
        chk("post_abort_add", 64'(out), 64'(5));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
